// File: rtl/multi_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts the selected operand one bit per clock
// by a run-time amount. Supports LSR, LSL, ASR, ROR and ROL, with carry-out and zero flags.
module multi_shift_unit #(
    parameter int alu_width = 16,
    parameter int amt_width = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [alu_width-1:0] A,
    input  logic [alu_width-1:0] B,
    input  logic                 shift_enable,
    input  logic                 operand_sel,
    input  logic [2:0]           alu_fun,
    input  logic [amt_width-1:0] amount,
    output logic                 busy,
    output logic                 shift_flag,
    output logic [alu_width-1:0] shift_out,
    output logic                 carry_out,
    output logic                 zero_flag
);

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef enum logic [2:0] {
        FUN_LSR = 3'b000,
        FUN_LSL = 3'b001,
        FUN_ASR = 3'b010,
        FUN_ROR = 3'b011,
        FUN_ROL = 3'b100
    } fun_t;

    state_t               state;
    logic [alu_width-1:0] work;
    logic [amt_width-1:0] count;
    logic [2:0]           mode;
    logic [alu_width-1:0] operand;
    logic [alu_width-1:0] next_work;
    logic                 next_carry;

    assign operand = operand_sel ? B : A;

    // One-bit step of the latched mode; reserved codes leave the work register untouched.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_work  = work;
        next_carry = 1'b0;
        case (mode)
            FUN_LSR: begin
                next_work  = {1'b0, work[alu_width-1:1]};
                next_carry = work[0];
            end
            FUN_LSL: begin
                next_work  = {work[alu_width-2:0], 1'b0};
                next_carry = work[alu_width-1];
            end
            FUN_ASR: begin
                next_work  = {work[alu_width-1], work[alu_width-1:1]};
                next_carry = work[0];
            end
            FUN_ROR: begin
                next_work  = {work[0], work[alu_width-1:1]};
                next_carry = work[0];
            end
            FUN_ROL: begin
                next_work  = {work[alu_width-2:0], work[alu_width-1]};
                next_carry = work[alu_width-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state      <= IDLE;
            work       <= '0;
            count      <= '0;
            mode       <= '0;
            busy       <= 1'b0;
            shift_flag <= 1'b0;
            shift_out  <= '0;
            carry_out  <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            shift_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (shift_enable) begin
                        work  <= operand;
                        count <= amount;
                        mode  <= alu_fun;
                        if (amount == '0) begin
                            shift_out  <= operand;
                            carry_out  <= 1'b0;
                            zero_flag  <= (operand == '0);
                            shift_flag <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work  <= next_work;
                    count <= count - amt_width'(1);
                    // Final step publishes the result directly from the step logic.
                    if (count == amt_width'(1)) begin
                        shift_out  <= next_work;
                        carry_out  <= next_carry;
                        zero_flag  <= (next_work == '0);
                        shift_flag <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_shift_unit.sv
// Self-checking bench for multi_shift_unit: scoreboard of expected results,
// computed by a closed-form reference model, compared at each completion.
module tb_multi_shift_unit;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          shift_enable;
    logic          operand_sel;
    logic [2:0]    alu_fun;
    logic [AW-1:0] amount;
    logic          busy;
    logic          shift_flag;
    logic [W-1:0]  shift_out;
    logic          carry_out;
    logic          zero_flag;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    multi_shift_unit #(.alu_width(W), .amt_width(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .shift_enable(shift_enable),
        .operand_sel (operand_sel),
        .alu_fun     (alu_fun),
        .amount      (amount),
        .busy        (busy),
        .shift_flag  (shift_flag),
        .shift_out   (shift_out),
        .carry_out   (carry_out),
        .zero_flag   (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form reference: whole-amount shifts on widened vectors, carry taken
    // from the bit position just beyond the result.
    function automatic exp_t model(input logic [W-1:0] x, input logic [2:0] fun, input int n);
        logic        [63:0] l;
        logic        [47:0] r;
        logic signed [47:0] s;
        int                 m;
        exp_t               e;
        e.res   = x;
        e.carry = 1'b0;
        m       = n % W;
        if (n != 0) begin
            case (fun)
                3'd0: begin r = {x, 32'b0} >> n; e.res = r[47:32]; e.carry = r[31]; end
                3'd1: begin l = {48'b0, x} << n; e.res = l[15:0];  e.carry = l[16];  end
                3'd2: begin s = $signed({x, 32'b0}) >>> n; e.res = s[47:32]; e.carry = s[31]; end
                3'd3: begin e.res = (x >> m) | (x << (W - m)); e.carry = e.res[W-1]; end
                3'd4: begin e.res = (x << m) | (x >> (W - m)); e.carry = e.res[0];   end
                default: ;
            endcase
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drives one request, scrambles inputs after the start edge, and waits
    // (bounded) for completion. Sampling is on the falling edge.
    task automatic run_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] fun, input logic [AW-1:0] amt,
                          output int lat, output int busy_cyc, output logic overlap);
        @(negedge clk);
        operand_sel  = sel;
        A            = a;
        B            = b;
        alu_fun      = fun;
        amount       = amt;
        shift_enable = 1'b1;
        sb.push_back(model(sel ? b : a, fun, int'(amt)));
        @(negedge clk);
        shift_enable = 1'b0;
        operand_sel  = ~sel;
        A            = ~a;
        B            = ~b;
        alu_fun      = 3'b111;
        amount       = ~amt;
        lat          = 0;
        busy_cyc     = 0;
        overlap      = 1'b0;
        while (!shift_flag && lat < 200) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        overlap = busy & shift_flag;
    endtask

    task automatic test_reset;
        rst          = 1'b0;
        A            = 16'hFFFF;
        B            = 16'hFFFF;
        operand_sel  = 1'b0;
        alu_fun      = 3'b000;
        amount       = '0;
        shift_enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, shift_flag, shift_out, carry_out, zero_flag} !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b flag=%b out=%h c=%b z=%b want all 0",
                     busy, shift_flag, shift_out, carry_out, zero_flag);
        end
        shift_enable = 1'b0;
        rst          = 1'b1;
    endtask

    task automatic test_lsr;
        int lat, bc; logic ov; exp_t e;
        run_op(1'b0, 16'h8001, 16'h0000, 3'b000, 5'd1, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero || shift_out !== 16'h4000) begin
            failures++;
            $display("FAIL lsr1: got %h c=%b z=%b want %h c=%b z=%b", shift_out, carry_out, zero_flag, e.res, e.carry, e.zero);
        end
        checks++;
        if (lat != 1 || bc != 1 || ov) begin
            failures++;
            $display("FAIL lsr1_timing: lat=%0d busy=%0d overlap=%b want 1 1 0", lat, bc, ov);
        end
        @(negedge clk);
        checks++;
        if (shift_flag !== 1'b0 || shift_out !== e.res) begin
            failures++;
            $display("FAIL lsr1_pulse: flag=%b out=%h want 0 %h", shift_flag, shift_out, e.res);
        end
    endtask

    task automatic test_asr;
        int lat, bc; logic ov; exp_t e;
        run_op(1'b1, 16'h1234, 16'h8000, 3'b010, 5'd15, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero) begin
            failures++;
            $display("FAIL asr15: got %h c=%b z=%b want %h c=%b z=%b", shift_out, carry_out, zero_flag, e.res, e.carry, e.zero);
        end
        checks++;
        if (lat != 15 || bc != 15 || ov) begin
            failures++;
            $display("FAIL asr15_timing: lat=%0d busy=%0d overlap=%b want 15 15 0", lat, bc, ov);
        end
    endtask

    task automatic test_rotate;
        logic [W-1:0]  xs[5] = '{16'h8001, 16'h0001, 16'hBEEF, 16'hBEEF, 16'h00F1};
        logic [2:0]    fs[5] = '{3'd4, 3'd3, 3'd4, 3'd3, 3'd4};
        logic [AW-1:0] ns[5] = '{5'd4, 5'd1, 5'd16, 5'd17, 5'd31};
        int lat, bc; logic ov; exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, xs[i], 16'h0000, fs[i], ns[i], lat, bc, ov);
            e = sb.pop_front();
            checks++;
            if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero) begin
                failures++;
                $display("FAIL rotate[%0d]: got %h c=%b z=%b want %h c=%b z=%b", i, shift_out, carry_out, zero_flag, e.res, e.carry, e.zero);
            end
            checks++;
            if (lat != int'(ns[i]) || bc != int'(ns[i]) || ov) begin
                failures++;
                $display("FAIL rotate[%0d]_timing: lat=%0d busy=%0d want %0d", i, lat, bc, ns[i]);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [W-1:0]  xs[3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
        logic [2:0]    fs[3] = '{3'd0, 3'd1, 3'd2};
        logic [AW-1:0] ns[3] = '{5'd20, 5'd16, 5'd31};
        int lat, bc; logic ov; exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, xs[i], 16'h0000, fs[i], ns[i], lat, bc, ov);
            e = sb.pop_front();
            checks++;
            if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero || lat != int'(ns[i])) begin
                failures++;
                $display("FAIL range[%0d]: got %h c=%b z=%b lat=%0d want %h c=%b z=%b lat=%0d",
                         i, shift_out, carry_out, zero_flag, lat, e.res, e.carry, e.zero, ns[i]);
            end
        end
    endtask

    task automatic test_amount_zero;
        logic [W-1:0]  xs[3] = '{16'h1234, 16'h0001, 16'h0000};
        logic [2:0]    fs[3] = '{3'd1, 3'd0, 3'd5};
        logic [AW-1:0] ns[3] = '{5'd0, 5'd1, 5'd3};
        int lat, bc; logic ov; exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, xs[i], 16'h0000, fs[i], ns[i], lat, bc, ov);
            e = sb.pop_front();
            checks++;
            if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero) begin
                failures++;
                $display("FAIL zero[%0d]: got %h c=%b z=%b want %h c=%b z=%b", i, shift_out, carry_out, zero_flag, e.res, e.carry, e.zero);
            end
            checks++;
            if (lat != int'(ns[i]) || bc != int'(ns[i]) || ov) begin
                failures++;
                $display("FAIL zero[%0d]_timing: lat=%0d busy=%0d overlap=%b want %0d", i, lat, bc, ov, ns[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   nflags;
        exp_t e;
        @(negedge clk);
        operand_sel  = 1'b0;
        alu_fun      = 3'b001;
        amount       = 5'd2;
        A            = 16'h0003;
        shift_enable = 1'b1;
        sb.push_back(model(16'h0003, 3'b001, 2));
        nflags = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin A = 16'h0005; sb.push_back(model(16'h0005, 3'b001, 2)); end
            if (i == 3) begin A = 16'hFFFF; sb.push_back(model(16'hFFFF, 3'b001, 2)); end
            if (i == 8) shift_enable = 1'b0;
            if (shift_flag) begin
                checks++;
                if (i != 2 + 3 * nflags || busy !== 1'b0 || sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_period: flag at cycle %0d busy=%b want cycle %0d busy=0", i, busy, 2 + 3 * nflags);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: got %h c=%b want %h c=%b", nflags, shift_out, carry_out, e.res, e.carry);
                    end
                end
                nflags++;
            end
        end
        checks++;
        if (nflags != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: flags=%0d busy=%b want 3 0", nflags, busy);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, bc, stray; logic ov; exp_t e;
        run_op(1'b0, 16'hABCD, 16'h0000, 3'b001, 5'd0, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (shift_out !== e.res) begin
            failures++;
            $display("FAIL pre_reset: got %h want %h", shift_out, e.res);
        end
        @(negedge clk);
        operand_sel  = 1'b0;
        alu_fun      = 3'b000;
        amount       = 5'd10;
        A            = 16'hFFFF;
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, shift_flag, shift_out, carry_out, zero_flag} !== '0) begin
            failures++;
            $display("FAIL mid_reset: busy=%b flag=%b out=%h c=%b z=%b want all 0",
                     busy, shift_flag, shift_out, carry_out, zero_flag);
        end
        rst   = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (shift_flag || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort: %0d cycles with busy/flag after reset, want 0", stray);
        end
        run_op(1'b0, 16'h00F0, 16'h0000, 3'b000, 5'd3, lat, bc, ov);
        e = sb.pop_front();
        checks++;
        if (shift_out !== e.res || carry_out !== e.carry || zero_flag !== e.zero || lat != 3) begin
            failures++;
            $display("FAIL post_reset: got %h c=%b z=%b lat=%0d want %h c=%b z=%b lat=3",
                     shift_out, carry_out, zero_flag, lat, e.res, e.carry, e.zero);
        end
    endtask

    initial begin
        test_reset();
        test_lsr();
        test_asr();
        test_rotate();
        test_out_of_range();
        test_amount_zero();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
